perf_counter_bank: RTL and testbench

PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

---
 rtl/perf_counter_bank.sv | 202 ++++++++++++++++++++
 tb/tb_perf_counter_bank.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: bank of NUM_COUNTERS event counters with a pipelined management read port.
// Latency: rd_valid/rd_data two cycles after an accepted rd_en; increments land at the next edge.
// Backpressure: none; one read per cycle is accepted, and responses return in issue order.
//
// Ports:
//   clk_mgmt, rst_mgmt   single clock (rising edge) and synchronous active-high reset
//   inc_en, inc_val      per-channel increment strobe and amount (channel i = inc_val[i*INC_WIDTH +: INC_WIDTH])
//   snap_en              capture all live counters into the shadow bank (snapshot build only)
//   clear_all            zero all live counters; wins over increments and clear-on-read
//   rd_en, rd_addr       read request: rd_addr[15:8] selects the bank, rd_addr[7:0] selects the channel
//   rd_valid, rd_data    one-cycle response strobe and zero-extended data; rd_data holds between responses
//
// Build option: define PERF_COUNTER_SNAPSHOT_EN to add the shadow bank. Reads then return shadow
// values, and clear-on-read clears the shadow entry. Without the macro, reads return live values
// and snap_en has no effect.
module perf_counter_bank #(
  parameter int         NUM_COUNTERS  = 8,
  parameter int         COUNTER_WIDTH = 48,
  parameter int         INC_WIDTH     = 16,
  parameter logic [7:0] BASE_ADDR     = 8'h10,
  parameter int         SATURATE      = 0,
  parameter int         CLEAR_ON_READ = 0
) (
  input  logic                              clk_mgmt,
  input  logic                              rst_mgmt,
  input  logic [NUM_COUNTERS-1:0]           inc_en,
  input  logic [NUM_COUNTERS*INC_WIDTH-1:0] inc_val,
  input  logic                              snap_en,
  input  logic                              clear_all,
  input  logic                              rd_en,
  input  logic [15:0]                       rd_addr,
  output logic                              rd_valid,
  output logic [63:0]                       rd_data
);

  // The sum is one bit wider than the wider operand, so the carry-out is visible for saturation.
  localparam int SUM_W = ((COUNTER_WIDTH > INC_WIDTH) ? COUNTER_WIDTH : INC_WIDTH) + 1;

  typedef logic [COUNTER_WIDTH-1:0] cnt_t;

  localparam cnt_t CNT_MAX = '1;

`ifdef PERF_COUNTER_SNAPSHOT_EN
  // Clear-on-read acts on the shadow entry, so the live counter never loses events.
  localparam bit COR_LIVE = 1'b0;
`else
  localparam bit COR_LIVE = (CLEAR_ON_READ != 0);
`endif

  // Adds the zero-extended increment and either wraps or saturates.
  function automatic cnt_t add_inc(input cnt_t base, input logic [INC_WIDTH-1:0] inc);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(base) + SUM_W'(inc);
    if ((SATURATE != 0) && (sum[SUM_W-1:COUNTER_WIDTH] != '0)) begin
      return CNT_MAX;
    end
    return sum[COUNTER_WIDTH-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  cnt_t        cnt_q [NUM_COUNTERS];
  cnt_t        cnt_d [NUM_COUNTERS];
  cnt_t        rd_src [NUM_COUNTERS];

  logic        s1_vld_q, s1_vld_d;
  cnt_t        s1_dat_q, s1_dat_d;
  logic        rd_valid_q, rd_valid_d;
  logic [63:0] rd_data_q, rd_data_d;

  // ---------------------------------------------------------------------------
  // Read decode
  // ---------------------------------------------------------------------------
  logic                    rd_acc;
  logic [7:0]              rd_idx;
  logic [NUM_COUNTERS-1:0] rd_hit;
  cnt_t                    rd_sel;

  // An out-of-range index matches no channel: rd_sel stays 0 and no clear-on-read fires.
  always_comb begin
    rd_acc = rd_en && (rd_addr[15:8] == BASE_ADDR);
    rd_idx = rd_addr[7:0];
    rd_hit = '0;
    rd_sel = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (rd_acc && (rd_idx == 8'(i))) begin
        rd_hit[i] = 1'b1;
        rd_sel    = rd_src[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Live counters
  // ---------------------------------------------------------------------------
  // Priority: clear_all, then clear-on-read, then increment. Clear-on-read zeroes the base
  // before the add, so an event arriving with the read is kept as the new count.
  always_comb begin
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clear_all) begin
        cnt_d[i] = '0;
      end else begin
        if (COR_LIVE && rd_hit[i]) begin
          cnt_d[i] = '0;
        end
        if (inc_en[i]) begin
          cnt_d[i] = add_inc(cnt_d[i], inc_val[i*INC_WIDTH +: INC_WIDTH]);
        end
      end
    end
  end

`ifdef PERF_COUNTER_SNAPSHOT_EN
  // ---------------------------------------------------------------------------
  // Shadow bank
  // ---------------------------------------------------------------------------
  cnt_t shd_q [NUM_COUNTERS];
  cnt_t shd_d [NUM_COUNTERS];

  // The snapshot copies cnt_q (the pre-increment value). A snapshot taken together with a
  // clearing read wins, so the shadow always holds a fresh capture.
  always_comb begin
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      shd_d[i] = shd_q[i];
      if (snap_en) begin
        shd_d[i] = cnt_q[i];
      end else if ((CLEAR_ON_READ != 0) && rd_hit[i]) begin
        shd_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk_mgmt) begin
    if (rst_mgmt) begin
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        shd_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        shd_q[i] <= shd_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      rd_src[i] = shd_q[i];
    end
  end
`else
  logic unused_snap_en;
  assign unused_snap_en = snap_en;

  always_comb begin
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      rd_src[i] = cnt_q[i];
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Read pipeline
  // ---------------------------------------------------------------------------
  // Stage 1 registers the decoded index's value at the rd_en edge. Capturing it here, rather
  // than indexing again in stage 2, returns the count as it stood before that cycle's
  // increment or clear. Stage 2 registers the response.
  always_comb begin
    s1_vld_d   = rd_acc;
    s1_dat_d   = rd_sel;
    rd_valid_d = s1_vld_q;
    rd_data_d  = rd_data_q;
    if (s1_vld_q) begin
      rd_data_d = 64'(s1_dat_q);
    end
  end

  always_ff @(posedge clk_mgmt) begin
    if (rst_mgmt) begin
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        cnt_q[i] <= '0;
      end
      s1_vld_q   <= 1'b0;
      s1_dat_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      s1_vld_q   <= s1_vld_d;
      s1_dat_q   <= s1_dat_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank: four perf_counter_bank configurations driven by shared stimulus.
// Each read pushes the expected response of every instance into a scoreboard, tagged with the
// cycle it is due; a negedge monitor checks rd_valid every cycle and pops/compares rd_data.
module tb_perf_counter_bank;

`ifdef PERF_COUNTER_SNAPSHOT_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_mgmt;
  logic [7:0]   inc_en;
  logic [127:0] inc_val;
  logic         snap_en;
  logic         clear_all;
  logic         rd_en;
  logic [15:0]  rd_addr;
  logic [3:0]   vld;
  logic [63:0]  dat [4];

  // Instance configuration: 0 default, 1 8-bit saturating, 2 8-bit wrapping, 3 clear-on-read.
  int cw_k  [4] = '{48, 8, 8, 48};
  int sat_k [4] = '{0, 1, 0, 0};
  int cor_k [4] = '{0, 0, 0, 1};

  perf_counter_bank #(.NUM_COUNTERS(8), .COUNTER_WIDTH(48), .INC_WIDTH(16), .BASE_ADDR(8'h10),
                      .SATURATE(0), .CLEAR_ON_READ(0)) u_dut (
    .clk_mgmt(clk), .rst_mgmt(rst_mgmt), .inc_en(inc_en), .inc_val(inc_val), .snap_en(snap_en),
    .clear_all(clear_all), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(vld[0]), .rd_data(dat[0]));

  perf_counter_bank #(.NUM_COUNTERS(8), .COUNTER_WIDTH(8), .INC_WIDTH(16), .BASE_ADDR(8'h10),
                      .SATURATE(1), .CLEAR_ON_READ(0)) u_sat (
    .clk_mgmt(clk), .rst_mgmt(rst_mgmt), .inc_en(inc_en), .inc_val(inc_val), .snap_en(snap_en),
    .clear_all(clear_all), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(vld[1]), .rd_data(dat[1]));

  perf_counter_bank #(.NUM_COUNTERS(8), .COUNTER_WIDTH(8), .INC_WIDTH(16), .BASE_ADDR(8'h10),
                      .SATURATE(0), .CLEAR_ON_READ(0)) u_wrap (
    .clk_mgmt(clk), .rst_mgmt(rst_mgmt), .inc_en(inc_en), .inc_val(inc_val), .snap_en(snap_en),
    .clear_all(clear_all), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(vld[2]), .rd_data(dat[2]));

  perf_counter_bank #(.NUM_COUNTERS(8), .COUNTER_WIDTH(48), .INC_WIDTH(16), .BASE_ADDR(8'h10),
                      .SATURATE(0), .CLEAR_ON_READ(1)) u_cor (
    .clk_mgmt(clk), .rst_mgmt(rst_mgmt), .inc_en(inc_en), .inc_val(inc_val), .snap_en(snap_en),
    .clear_all(clear_all), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(vld[3]), .rd_data(dat[3]));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int               due;
    logic [3:0][63:0] dat;
  } exp_t;

  exp_t        sb_q [$];
  logic [63:0] mcnt [4][8];
  logic [63:0] mshd [4][8];
  logic [63:0] last_exp [4];
  int          chk_cnt = 0;
  int          err_cnt = 0;
  logic        mon_en = 1'b0;
  logic        due_now;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one cycle of inputs, advances the reference model over that cycle, and queues the
  // expected response of an accepted read two cycles ahead.
  task automatic step(input logic r, input logic [7:0] ie, input logic [127:0] iv,
                      input logic sn, input logic ca, input logic re, input logic [15:0] ad);
    exp_t        e;
    logic        acc;
    int          idx;
    logic [63:0] mx;
    logic [63:0] nc;
    rst_mgmt  = r;
    inc_en    = ie;
    inc_val   = iv;
    snap_en   = sn;
    clear_all = ca;
    rd_en     = re;
    rd_addr   = ad;
    if (r) begin
      for (int k = 0; k < 4; k++) begin
        for (int c = 0; c < 8; c++) begin
          mcnt[k][c] = '0;
          mshd[k][c] = '0;
        end
      end
      while (sb_q.size() > 0 && sb_q[$].due > cyc) void'(sb_q.pop_back());
    end else begin
      acc   = re && (ad[15:8] == 8'h10);
      idx   = int'(ad[7:0]);
      e.due = cyc + 2;
      e.dat = '0;
      for (int k = 0; k < 4; k++) begin
        mx = (64'd1 << cw_k[k]) - 64'd1;
        if (acc && idx < 8) e.dat[k] = SNAP ? mshd[k][idx] : mcnt[k][idx];
        if (SNAP) begin
          if (sn) begin
            for (int c = 0; c < 8; c++) mshd[k][c] = mcnt[k][c];
          end else if (cor_k[k] != 0 && acc && idx < 8) begin
            mshd[k][idx] = '0;
          end
        end
        for (int c = 0; c < 8; c++) begin
          if (ca) begin
            nc = '0;
          end else begin
            nc = (!SNAP && cor_k[k] != 0 && acc && idx == c) ? 64'd0 : mcnt[k][c];
            if (ie[c]) begin
              nc = nc + 64'(iv[c*16 +: 16]);
              if (nc > mx) nc = (sat_k[k] != 0) ? mx : (nc & mx);
            end
          end
          mcnt[k][c] = nc;
        end
      end
      if (acc) sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, '0, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic rd(input logic [15:0] a);
    step(1'b0, 8'h00, '0, 1'b0, 1'b0, 1'b1, a);
  endtask

  function automatic logic [127:0] one_inc(input int ch, input logic [15:0] v);
    logic [127:0] t;
    t = '0;
    t[ch*16 +: 16] = v;
    return t;
  endfunction

  // Every cycle each instance must show rd_valid exactly when a response is due.
  always @(negedge clk) begin
    if (mon_en) begin
      due_now = (sb_q.size() > 0) && (sb_q[0].due == cyc);
      for (int k = 0; k < 4; k++) begin
        check_val($sformatf("rd_valid inst%0d cyc%0d", k, cyc), 64'(vld[k]), 64'(due_now));
      end
      if (due_now) begin
        for (int k = 0; k < 4; k++) begin
          check_val($sformatf("rd_data inst%0d cyc%0d", k, cyc), dat[k], sb_q[0].dat[k]);
          last_exp[k] = sb_q[0].dat[k];
        end
        void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    for (int k = 0; k < 4; k++) last_exp[k] = '0;
    for (int k = 0; k < 4; k++) for (int c = 0; c < 8; c++) begin
      mcnt[k][c] = '0;
      mshd[k][c] = '0;
    end

    // Reset state
    step(1'b1, 8'h00, '0, 1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 8'h00, '0, 1'b0, 1'b0, 1'b0, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      check_val($sformatf("reset rd_valid inst%0d", k), 64'(vld[k]), 64'd0);
      check_val($sformatf("reset rd_data inst%0d", k), dat[k], 64'd0);
    end
    mon_en = 1'b1;

    // Ten increments of 5 on channel 2, then read 0x1002 (50 everywhere)
    for (int i = 0; i < 10; i++) step(1'b0, 8'h04, one_inc(2, 16'd5), 1'b0, 1'b0, 1'b0, 16'h0000);
    rd(16'h1002);
    idle(3);

    // Channel 0 at 250 plus 10: saturates to 255, wraps to 4, 260 at full width
    step(1'b0, 8'h00, '0, 1'b0, 1'b1, 1'b0, 16'h0000);
    step(1'b0, 8'h01, one_inc(0, 16'd250), 1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 8'h01, one_inc(0, 16'd10), 1'b0, 1'b0, 1'b0, 16'h0000);
    rd(16'h1000);
    idle(3);

    // Channel 1 at 7, clearing read coincident with +3, then a second read
    step(1'b0, 8'h00, '0, 1'b0, 1'b1, 1'b0, 16'h0000);
    step(1'b0, 8'h02, one_inc(1, 16'd7), 1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 8'h02, one_inc(1, 16'd3), 1'b0, 1'b0, 1'b1, 16'h1001);
    rd(16'h1001);
    idle(4);
    for (int k = 0; k < 4; k++) check_val($sformatf("rd_data hold inst%0d", k), dat[k], last_exp[k]);

    // Distinct per-channel values, back-to-back reads, out-of-range index, foreign bank
    step(1'b0, 8'h00, '0, 1'b0, 1'b1, 1'b0, 16'h0000);
    for (int c = 0; c < 8; c++) step(1'b0, 8'(1 << c), one_inc(c, 16'(c * 3 + 1)), 1'b0, 1'b0, 1'b0, 16'h0000);
    rd(16'h1000);
    rd(16'h1001);
    rd(16'h1002);
    rd(16'h1003);
    rd(16'h1020);
    rd(16'h2000);
    idle(3);

    // clear_all coincident with an increment discards the increment
    step(1'b0, 8'hFF, {8{16'd9}}, 1'b0, 1'b1, 1'b1, 16'h1005);
    rd(16'h1005);
    idle(3);

    // Randomised traffic: increments, reads (some to another bank), rare snapshots and clears
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 8'($urandom), {$urandom, $urandom, $urandom, $urandom},
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
           {(($urandom_range(0, 3) == 0) ? 8'h20 : 8'h10), 8'($urandom_range(0, 9))});
    end
    idle(3);

    // Channel 0 at 100, snapshot, 20 more increments, read (100 with shadow, 120 live)
    step(1'b0, 8'h00, '0, 1'b0, 1'b1, 1'b0, 16'h0000);
    step(1'b0, 8'h01, one_inc(0, 16'd100), 1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 8'h01, one_inc(0, 16'd1), 1'b1, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 19; i++) step(1'b0, 8'h01, one_inc(0, 16'd1), 1'b0, 1'b0, 1'b0, 16'h0000);
    rd(16'h1000);
    idle(3);

    // Reset one cycle after a read: no response; inputs during reset ignored; all channels 0
    for (int c = 0; c < 8; c++) step(1'b0, 8'hFF, {8{16'd11}}, 1'b1, 1'b0, 1'b0, 16'h0000);
    rd(16'h1003);
    step(1'b1, 8'hFF, {8{16'd7}}, 1'b1, 1'b1, 1'b1, 16'h1004);
    idle(1);
    for (int k = 0; k < 4; k++) check_val($sformatf("post-reset rd_data inst%0d", k), dat[k], 64'd0);
    for (int c = 0; c < 8; c++) rd(16'h1000 + 16'(c));
    idle(4);

    check_val("scoreboard drained", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
